// File: rtl/clock_switch_seq_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clock_switch_seq_m: HS/LS CPU clock-switch sequencer with RDY stall.     |
// | Optional build macro: CLOCK_SWITCH_SEQ_STATS_EN (switch completion count)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clock_switch_seq_m #(
  parameter int LINGER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        ck_ip,
  input  logic        resetb,
  input  logic        slow_req_ip,
  input  logic        force_slow_ip,
  input  logic        selected_hs_ip,
  input  logic        selected_ls_ip,
`ifdef CLOCK_SWITCH_SEQ_STATS_EN
  input  logic        stats_clr_ip,
  output logic [15:0] switch_count_op,
`endif
  output logic        select_hs_op,
  output logic        rdy_op,
  output logic        fast_op,
  output logic        timeout_err_op
);

  localparam logic [1:0] ST_SLOW    = 2'd0;
  localparam logic [1:0] ST_TO_FAST = 2'd1;
  localparam logic [1:0] ST_FAST    = 2'd2;
  localparam logic [1:0] ST_TO_SLOW = 2'd3;

  localparam logic [CNT_W-1:0] LINGER_C  = CNT_W'(LINGER_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             select_hs_q, select_hs_d;
  logic             rdy_q, rdy_d;
  logic             fast_q, fast_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             hs_locked;
  logic             ls_locked;
  logic             want_slow;

  // Mixed status (both high or both low) is treated as still switching.
  assign hs_locked = selected_hs_ip & ~selected_ls_ip;
  assign ls_locked = selected_ls_ip & ~selected_hs_ip;
  assign want_slow = slow_req_ip | force_slow_ip;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_FAST: begin
        if (want_slow) begin
          state_d = ST_TO_SLOW;
          cnt_d   = '0;
        end
      end
      ST_TO_SLOW: begin
        if (ls_locked) begin
          state_d = ST_SLOW;
          cnt_d   = LINGER_C;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_C) err_d = 1'b1;
        end
      end
      ST_SLOW: begin
        if (want_slow) begin
          cnt_d = LINGER_C;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_TO_FAST;
          cnt_d   = '0;
        end
      end
      ST_TO_FAST: begin
        if (hs_locked) begin
          state_d = ST_FAST;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_C) err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_SLOW;
        cnt_d   = LINGER_C;
      end
    endcase
  end

  // Outputs are a pure function of the state being entered, registered.
  always_comb begin
    select_hs_d = (state_d == ST_FAST) || (state_d == ST_TO_FAST);
    rdy_d       = (state_d == ST_FAST) || (state_d == ST_SLOW);
    fast_d      = (state_d == ST_FAST);
  end

  always_ff @(posedge ck_ip) begin
    if (!resetb) begin
      state_q     <= ST_SLOW;
      cnt_q       <= LINGER_C;
      select_hs_q <= 1'b0;
      rdy_q       <= 1'b1;
      fast_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      select_hs_q <= select_hs_d;
      rdy_q       <= rdy_d;
      fast_q      <= fast_d;
      err_q       <= err_d;
    end
  end

  assign select_hs_op   = select_hs_q;
  assign rdy_op         = rdy_q;
  assign fast_op        = fast_q;
  assign timeout_err_op = err_q;

`ifdef CLOCK_SWITCH_SEQ_STATS_EN
  logic [15:0] switch_count_q, switch_count_d;

  // Clear has priority over a completion on the same edge.
  always_comb begin
    switch_count_d = switch_count_q;
    if (stats_clr_ip) begin
      switch_count_d = '0;
    end else if ((state_q == ST_TO_FAST) && hs_locked && (switch_count_q != 16'hFFFF)) begin
      switch_count_d = switch_count_q + 16'd1;
    end
  end

  always_ff @(posedge ck_ip) begin
    if (!resetb) begin
      switch_count_q <= '0;
    end else begin
      switch_count_q <= switch_count_d;
    end
  end

  assign switch_count_op = switch_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_switch_seq_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clock_switch_seq_m: scoreboard bench for clock_switch_seq_m.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_clock_switch_seq_m;

  localparam int LINGER    = 4;
  localparam int TIMEOUT   = 64;
  localparam int M_SLOW    = 0;
  localparam int M_TO_FAST = 1;
  localparam int M_FAST    = 2;
  localparam int M_TO_SLOW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb = 1'b0;
  logic req  = 1'b0;
  logic frc  = 1'b0;
  logic clr  = 1'b0;
  logic st_hs = 1'b0;
  logic st_ls = 1'b1;
  logic sel_o, rdy_o, fast_o, err_o;
  logic [15:0] count_o;

  clock_switch_seq_m #(
    .LINGER_CYCLES (LINGER),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (8)
  ) dut (
    .ck_ip          (clk),
    .resetb         (rstb),
    .slow_req_ip    (req),
    .force_slow_ip  (frc),
    .selected_hs_ip (st_hs),
    .selected_ls_ip (st_ls),
`ifdef CLOCK_SWITCH_SEQ_STATS_EN
    .stats_clr_ip   (clr),
    .switch_count_op(count_o),
`endif
    .select_hs_op   (sel_o),
    .rdy_op         (rdy_o),
    .fast_op        (fast_o),
    .timeout_err_op (err_o)
  );

`ifndef CLOCK_SWITCH_SEQ_STATS_EN
  assign count_o = 16'd0;
`endif

  typedef struct {
    logic        sel;
    logic        rdy;
    logic        fast;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: mode plus "idle cycles seen in SLOW" and "cycles waited".
  int m_mode  = M_SLOW;
  int m_quiet = 0;
  int m_wait  = 0;
  bit m_err   = 1'b0;
  int m_count = 0;

  // Behavioural clock switch: follows the requested select after a random delay.
  bit sw_hs    = 1'b0;
  int sw_dly   = 0;
  bit stuck    = 1'b0;
  bit stuck_hs = 1'b0;

  task automatic check1(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check1("select_hs", {15'd0, sel_o},  {15'd0, e.sel});
      check1("rdy",       {15'd0, rdy_o},  {15'd0, e.rdy});
      check1("fast",      {15'd0, fast_o}, {15'd0, e.fast});
      check1("timeout_err", {15'd0, err_o}, {15'd0, e.err});
`ifdef CLOCK_SWITCH_SEQ_STATS_EN
      check1("switch_count", count_o, e.cnt);
`endif
    end
  end

  task automatic step(input bit r, input bit f, input bit c, input bit rst_n);
    bit   tgt;
    exp_t e;
    @(negedge clk);
    #1;
    tgt = (m_mode == M_FAST) || (m_mode == M_TO_FAST);
    if (sw_hs != tgt) begin
      if (sw_dly == 0) sw_hs = tgt;
      else sw_dly--;
    end else begin
      sw_dly = $urandom_range(0, 4);
    end
    if (stuck) begin
      st_hs = stuck_hs;
      st_ls = ~stuck_hs;
    end else if (sw_hs != tgt) begin
      case ($urandom_range(0, 2))
        0:       begin st_hs = sw_hs; st_ls = ~sw_hs; end
        1:       begin st_hs = 1'b0;  st_ls = 1'b0;   end
        default: begin st_hs = 1'b1;  st_ls = 1'b1;   end
      endcase
    end else begin
      st_hs = sw_hs;
      st_ls = ~sw_hs;
    end
    rstb = rst_n;
    req  = r;
    frc  = f;
    clr  = c;

    if (!rst_n) begin
      m_mode  = M_SLOW;
      m_quiet = 0;
      m_wait  = 0;
      m_err   = 1'b0;
      m_count = 0;
    end else begin
      case (m_mode)
        M_FAST: if (r || f) begin m_mode = M_TO_SLOW; m_wait = 0; end
        M_TO_SLOW: begin
          if (st_ls && !st_hs) begin
            m_mode  = M_SLOW;
            m_quiet = 0;
          end else begin
            m_wait++;
            if (m_wait >= TIMEOUT) m_err = 1'b1;
          end
        end
        M_SLOW: begin
          if (r || f) m_quiet = 0;
          else if (m_quiet == LINGER) begin m_mode = M_TO_FAST; m_wait = 0; end
          else m_quiet++;
        end
        default: begin
          if (st_hs && !st_ls) begin
            m_mode = M_FAST;
            if (m_count < 65535) m_count++;
          end else begin
            m_wait++;
            if (m_wait >= TIMEOUT) m_err = 1'b1;
          end
        end
      endcase
      if (c) m_count = 0;
    end

    e.sel  = (m_mode == M_FAST) || (m_mode == M_TO_FAST);
    e.rdy  = (m_mode == M_FAST) || (m_mode == M_SLOW);
    e.fast = (m_mode == M_FAST);
    e.err  = m_err;
    e.cnt  = 16'(m_count);
    sb.push_back(e);
  endtask

  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Idle start: SLOW linger, switch to fast, FAST.
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1);
    // Single slow pulse and round trip.
    step(1, 0, 0, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1);
    // Periodic slow requests keep the CPU on the slow clock.
    step(1, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 21; i++) step(i % 3 == 0, 0, 0, 1);
    // Switch stuck on LS while heading to FAST: timeout, then recovery.
    stuck    = 1'b1;
    stuck_hs = 1'b0;
    for (int i = 0; i < 80; i++) step(0, 0, 0, 1);
    stuck = 1'b0;
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1);
    // Forced slow, then release.
    for (int i = 0; i < 30; i++) step(0, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    // Reset while in TO_FAST.
    step(1, 0, 0, 1);
    for (int i = 0; i < 40 && m_mode != M_TO_FAST; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    // Randomised traffic with occasional reset and stats clear.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 299) != 0);
    @(negedge clk);
    @(negedge clk);
    check1("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_switch_seq_m.md
Name: clock_switch_seq_m

Overview:
Sequencer that drives the select input of the HS/LS CPU clock switch. It decides when the CPU runs on the fast or slow clock from a per-access slow-request decode and a force-slow config bit. It waits for the switch's selected-clock status before releasing the CPU, and stalls the CPU via RDY while a switch is in flight. It is clocked by the switch's output clock, so every cycle count here is in CPU clock cycles, whichever source is selected.

Parameters:
LINGER_CYCLES, 4, cycles to stay in SLOW after the last slow request before returning to fast (0 = return immediately).
TIMEOUT_CYCLES, 64, maximum cycles to wait for switch status before flagging an error.
CNT_W, 8, width of the internal linger/timeout counter; must hold max(LINGER_CYCLES, TIMEOUT_CYCLES).

Ports:
ck_ip  in  1  CPU clock (output of clock switch); all logic on rising edge
resetb  in  1  synchronous, active-low reset, sampled on rising ck_ip
slow_req_ip  in  1  current CPU access targets slow (host) space; valid each cycle
force_slow_ip  in  1  config: hold CPU on slow clock while high
selected_hs_ip  in  1  switch status: HS clock enabled
selected_ls_ip  in  1  switch status: LS clock enabled
select_hs_op  out  1  to switch select_hs input
rdy_op  out  1  CPU RDY; 0 stalls CPU
fast_op  out  1  high only in FAST state
timeout_err_op  out  1  sticky: a switch exceeded TIMEOUT_CYCLES

Behaviour:
- One clock and a synchronous active-low reset (resetb). All state changes on rising ck_ip.
- Reset (resetb=0 at an edge): state=SLOW, counter=LINGER_CYCLES, select_hs_op=0, rdy_op=1, fast_op=0, timeout_err_op=0. Reset mid-switch aborts to SLOW the same way.
- Outputs are registered; they change only on the edge that enters a state.
- State FAST: select_hs_op=1, rdy_op=1, fast_op=1.
  - If slow_req_ip | force_slow_ip: go to TO_SLOW, clear counter.
- State TO_SLOW: select_hs_op=0, rdy_op=0.
  - When selected_ls_ip=1 and selected_hs_ip=0: go to SLOW, load counter=LINGER_CYCLES, rdy_op=1 on the same edge.
  - Otherwise counter increments, saturating at all-ones.
  - When counter reaches TIMEOUT_CYCLES, set timeout_err_op (sticky until reset) and keep waiting.
- State SLOW: select_hs_op=0, rdy_op=1.
  - If slow_req_ip | force_slow_ip: reload counter=LINGER_CYCLES.
  - Else if counter!=0: decrement.
  - Else (counter==0, no request, not forced): go to TO_FAST, clear counter.
  - Example: with LINGER_CYCLES=4, a single slow access is followed by 4 non-slow cycles in SLOW, then TO_FAST.
- State TO_FAST: select_hs_op=1, rdy_op=0.
  - When selected_hs_ip=1 and selected_ls_ip=0: go to FAST.
  - Timeout handling is identical to TO_SLOW.
  - slow_req_ip and force_slow_ip are ignored here because the CPU is stalled. On FAST entry they are re-evaluated the next cycle, so a pending slow request produces FAST for 1 cycle, then TO_SLOW.
- Status with both selected_* high, or both low, counts as "not yet switched" in either transition state.
- In FAST and SLOW, selected_* are ignored.
- Simultaneous force_slow_ip and slow_req_ip behave the same as either alone.
- State encoding is left to synthesis; there are no unreachable states beyond the 4 listed. An illegal state recovers to SLOW.

Optional Feature:
CLOCK_SWITCH_SEQ_STATS_EN
- Defined: adds 16-bit output switch_count_op and 1-bit input stats_clr_ip.
  - switch_count_op increments, saturating at 0xFFFF, on each TO_FAST->FAST completion.
  - stats_clr_ip=1 clears it at the next edge; clear wins over a simultaneous increment.
  - Reset value is 0.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset with resetb=0 for 2 cycles, then all inputs 0, status LS=1/HS=0 -> SLOW for 4 cycles. Then select_hs_op=1 and rdy_op=0; drive HS=1/LS=0 two cycles later -> FAST, rdy_op=1, fast_op=1.
- In FAST, pulse slow_req_ip 1 cycle -> next edge select_hs_op=0, rdy_op=0. Drive LS=1/HS=0 after 3 cycles -> rdy_op=1 in SLOW, then return to FAST after LINGER_CYCLES=4 idle cycles.
- In SLOW, slow_req_ip asserted every 3rd cycle for 20 cycles -> never leaves SLOW; counter reload verified.
- In TO_FAST, hold status at LS=1/HS=0 for 70 cycles -> timeout_err_op rises after 64 cycles and stays 1. Release status -> FAST reached, error still 1 until reset.
- force_slow_ip=1 in FAST -> TO_SLOW then SLOW, held indefinitely. Deassert -> exit after 4 cycles. Assert resetb=0 during TO_FAST -> SLOW, error cleared.
- With CLOCK_SWITCH_SEQ_STATS_EN: 3 full slow->fast round trips -> switch_count_op=3. stats_clr_ip on the same edge as a 4th completion -> 0.
